// File: rtl/dr_scan_register.sv
// Multi-bit dual-rail scan register: picks one of NCH dual-rail channels by one-hot select under a four-phase req/ack handshake.
// Null bits (00) hold the stored value; illegal codes or bad selects replay the store and raise err.
module dr_scan_register #(
    parameter int               WIDTH   = 4,
    parameter int               NCH     = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   in_0,
    input  logic [NCH*WIDTH-1:0]   in_1,
    input  logic [NCH-1:0]         sel,
    input  logic                   req,
    output logic [WIDTH-1:0]       q0,
    output logic [WIDTH-1:0]       q1,
    output logic                   ack,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_DRIVE,
        S_ACK,
        S_CLEAR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] store_q, store_d;
    logic [WIDTH-1:0] q0_q, q0_d;
    logic [WIDTH-1:0] q1_q, q1_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] ch_t, ch_f, val;
    logic             bad;

    // With a legal one-hot select the OR-merge is exactly the selected channel.
    always_comb begin
        ch_t = '0;
        ch_f = '0;
        for (int c = 0; c < NCH; c++) begin
            if (sel[c]) begin
                ch_t = ch_t | in_1[c*WIDTH +: WIDTH];
                ch_f = ch_f | in_0[c*WIDTH +: WIDTH];
            end
        end
        bad = !$onehot(sel) || (|(ch_t & ch_f));
        val = (ch_t & ~ch_f) | (store_q & ~(ch_t | ch_f));
    end

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        q0_d    = q0_q;
        q1_d    = q1_q;
        ack_d   = ack_q;
        err_d   = err_q;
        unique case (state_q)
            S_SYNC: begin
                if (!req) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (req) begin
                    state_d = S_DRIVE;
                    if (bad) begin
                        q1_d  = store_q;
                        q0_d  = ~store_q;
                        err_d = 1'b1;
                    end else begin
                        q1_d    = val;
                        q0_d    = ~val;
                        store_d = val;
                        err_d   = 1'b0;
                    end
                end
            end
            S_DRIVE: begin
                state_d = S_ACK;
                ack_d   = 1'b1;
            end
            S_ACK: begin
                if (!req) begin
                    state_d = S_CLEAR;
                    q0_d    = '0;
                    q1_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SYNC;
            store_q <= RST_VAL;
            q0_q    <= '0;
            q1_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign q0  = q0_q;
    assign q1  = q1_q;
    assign ack = ack_q;
    assign err = err_q;

endmodule

// File: tb/tb_dr_scan_register.sv
// Bench for dr_scan_register at default parameters: scoreboarded handshakes with a reference decode model.
module tb_dr_scan_register;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_0, in_1;
    logic [1:0] sel;
    logic       req;
    logic [3:0] q0, q1;
    logic       ack, err;

    dr_scan_register dut (
        .clk  (clk),
        .rst  (rst),
        .in_0 (in_0),
        .in_1 (in_1),
        .sel  (sel),
        .req  (req),
        .q0   (q0),
        .q1   (q1),
        .ack  (ack),
        .err  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] q0;
        logic [3:0] q1;
        logic       err;
        logic [3:0] st;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] mstore;
    int         checks   = 0;
    int         failures = 0;

    logic [3:0] obs_q0, obs_q1, obs_qrel;
    logic       obs_err, obs_ack_early, obs_ack, obs_ack_hold, obs_ack_end;

    function automatic exp_t model(input logic [3:0] st, input logic [1:0] s,
                                   input logic [7:0] i0, input logic [7:0] i1);
        exp_t r;
        int   n  = 0;
        int   ch = 0;
        logic v;
        for (int k = 0; k < 2; k++) if (s[k]) begin n++; ch = k; end
        r.err = (n != 1);
        if (!r.err)
            for (int i = 0; i < 4; i++)
                if (i1[ch*4+i] && i0[ch*4+i]) r.err = 1'b1;
        if (r.err) begin
            r.q1 = st; r.q0 = ~st; r.st = st;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i1[ch*4+i])      v = 1'b1;
                else if (i0[ch*4+i]) v = 1'b0;
                else                 v = st[i];
                r.q1[i] = v; r.q0[i] = ~v; r.st[i] = v;
            end
        end
        return r;
    endfunction

    // Full four-phase handshake; called and returns on a falling edge with the DUT in IDLE.
    task automatic send(input logic [1:0] s, input logic [7:0] i0, input logic [7:0] i1);
        exp_t e;
        e = model(mstore, s, i0, i1);
        exp_q.push_back(e);
        mstore = e.st;
        sel = s; in_0 = i0; in_1 = i1; req = 1'b1;
        @(negedge clk);
        obs_q0 = q0; obs_q1 = q1; obs_ack_early = ack;
        @(negedge clk);
        obs_ack = ack; obs_err = err;
        // Garbage on the bundle once accepted must not leak into the result.
        req = 1'b0; sel = 2'b11; in_0 = 8'hFF; in_1 = 8'hFF;
        @(negedge clk);
        obs_qrel = q0 | q1; obs_ack_hold = ack;
        @(negedge clk);
        obs_ack_end = ack;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; sel = 2'b01; in_0 = '0; in_1 = '0;
        mstore = 4'b0000;
        @(negedge clk); @(negedge clk);
        checks++; if (q0 !== 4'b0000) begin failures++; $display("FAIL reset_q0 got=%b exp=0000", q0); end
        checks++; if (q1 !== 4'b0000) begin failures++; $display("FAIL reset_q1 got=%b exp=0000", q1); end
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t e;
        send(2'b01, 8'b0000_1010, 8'b0000_0101);
        e = exp_q.pop_front();
        checks++; if (obs_q1 !== e.q1) begin failures++; $display("FAIL basic_q1 got=%b exp=%b", obs_q1, e.q1); end
        checks++; if (obs_q0 !== e.q0) begin failures++; $display("FAIL basic_q0 got=%b exp=%b", obs_q0, e.q0); end
        checks++; if (obs_q1 !== 4'b0101) begin failures++; $display("FAIL basic_q1_const got=%b exp=0101", obs_q1); end
        checks++; if (obs_ack_early !== 1'b0) begin failures++; $display("FAIL basic_ack_early got=%b exp=0", obs_ack_early); end
        checks++; if (obs_ack !== 1'b1) begin failures++; $display("FAIL basic_ack got=%b exp=1", obs_ack); end
        checks++; if (obs_err !== e.err) begin failures++; $display("FAIL basic_err got=%b exp=%b", obs_err, e.err); end
        checks++; if (obs_qrel !== 4'b0000) begin failures++; $display("FAIL basic_q_release got=%b exp=0000", obs_qrel); end
        checks++; if (obs_ack_hold !== 1'b1) begin failures++; $display("FAIL basic_ack_hold got=%b exp=1", obs_ack_hold); end
        checks++; if (obs_ack_end !== 1'b0) begin failures++; $display("FAIL basic_ack_end got=%b exp=0", obs_ack_end); end
    endtask

    task automatic test_null_hold();
        exp_t e;
        send(2'b01, 8'b0000_0001, 8'b0000_1000);
        e = exp_q.pop_front();
        checks++; if (obs_q1 !== 4'b1100 || obs_q1 !== e.q1) begin failures++; $display("FAIL null_q1 got=%b exp=%b", obs_q1, e.q1); end
        checks++; if (obs_q0 !== e.q0) begin failures++; $display("FAIL null_q0 got=%b exp=%b", obs_q0, e.q0); end
        checks++; if (obs_err !== e.err) begin failures++; $display("FAIL null_err got=%b exp=%b", obs_err, e.err); end
        send(2'b01, 8'h00, 8'h00);
        e = exp_q.pop_front();
        checks++; if (obs_q1 !== e.q1) begin failures++; $display("FAIL null_all_q1 got=%b exp=%b", obs_q1, e.q1); end
    endtask

    task automatic test_channel_select();
        exp_t e;
        send(2'b10, 8'b1100_1111, 8'b0011_1111);
        e = exp_q.pop_front();
        checks++; if (obs_q1 !== e.q1) begin failures++; $display("FAIL chsel_q1 got=%b exp=%b", obs_q1, e.q1); end
        checks++; if (obs_q0 !== e.q0) begin failures++; $display("FAIL chsel_q0 got=%b exp=%b", obs_q0, e.q0); end
        checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL chsel_err got=%b exp=0", obs_err); end
    endtask

    task automatic test_bad_select();
        exp_t        e;
        logic [1:0]  sels [2];
        sels[0] = 2'b00; sels[1] = 2'b11;
        for (int k = 0; k < 2; k++) begin
            send(sels[k], 8'b0101_0110, 8'b1010_1001);
            e = exp_q.pop_front();
            checks++; if (obs_err !== e.err) begin failures++; $display("FAIL badsel%0d_err got=%b exp=%b", k, obs_err, e.err); end
            checks++; if (obs_ack !== 1'b1) begin failures++; $display("FAIL badsel%0d_ack got=%b exp=1", k, obs_ack); end
            checks++; if (obs_q1 !== e.q1) begin failures++; $display("FAIL badsel%0d_q1 got=%b exp=%b", k, obs_q1, e.q1); end
            send(2'b01, 8'h00, 8'h00);
            e = exp_q.pop_front();
            checks++; if (obs_q1 !== e.q1) begin failures++; $display("FAIL badsel%0d_store got=%b exp=%b", k, obs_q1, e.q1); end
        end
    endtask

    task automatic test_illegal_code();
        exp_t e;
        send(2'b01, 8'b0000_0101, 8'b0000_0110);
        e = exp_q.pop_front();
        checks++; if (obs_err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", obs_err); end
        checks++; if (obs_q1 !== e.q1) begin failures++; $display("FAIL illegal_q1 got=%b exp=%b", obs_q1, e.q1); end
        checks++; if (obs_q0 !== e.q0) begin failures++; $display("FAIL illegal_q0 got=%b exp=%b", obs_q0, e.q0); end
        send(2'b01, 8'h00, 8'h00);
        e = exp_q.pop_front();
        checks++; if (obs_q1 !== e.q1) begin failures++; $display("FAIL illegal_store got=%b exp=%b", obs_q1, e.q1); end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [7:0] a, b;
        logic [1:0] s;
        for (int n = 0; n < 12; n++) begin
            a = 8'($urandom); b = 8'($urandom);
            s = (n % 4 == 3) ? 2'($urandom) : ((n % 2 == 0) ? 2'b01 : 2'b10);
            send(s, a, b);
            e = exp_q.pop_front();
            checks++;
            if (obs_q1 !== e.q1 || obs_q0 !== e.q0 || obs_err !== e.err || obs_ack !== 1'b1) begin
                failures++;
                $display("FAIL b2b%0d got q1=%b q0=%b err=%b ack=%b exp q1=%b q0=%b err=%b ack=1",
                         n, obs_q1, obs_q0, obs_err, obs_ack, e.q1, e.q0, e.err);
            end
        end
    endtask

    task automatic test_reset_mid_handshake();
        exp_t e;
        sel = 2'b01; in_0 = 8'b0000_0011; in_1 = 8'b0000_1100; req = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mstore = 4'b0000;
        checks++;
        if (q0 !== 4'b0000 || q1 !== 4'b0000 || ack !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs got q0=%b q1=%b ack=%b err=%b exp all 0", q0, q1, ack, err);
        end
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0 || q1 !== 4'b0000) begin
                failures++;
                $display("FAIL midrst_sync%0d got ack=%b q1=%b exp ack=0 q1=0000", n, ack, q1);
            end
        end
        req = 1'b0;
        @(negedge clk);
        send(2'b01, 8'h00, 8'h00);
        e = exp_q.pop_front();
        checks++; if (obs_q0 !== 4'b1111 || obs_q0 !== e.q0) begin failures++; $display("FAIL midrst_q0 got=%b exp=%b", obs_q0, e.q0); end
        checks++; if (obs_ack !== 1'b1) begin failures++; $display("FAIL midrst_ack got=%b exp=1", obs_ack); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_null_hold();
        test_channel_select();
        test_bad_select();
        test_illegal_code();
        test_back_to_back();
        test_reset_mid_handshake();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
